decode: RTL and testbench

//  Decode stage of the 5-stage RV32I pipeline; consumes fe_to_de_s from the fetch stage.

---
 rtl/decode_pkg.sv | 133 +++++++++++++
 rtl/decode_reg_file.sv | 65 ++++++
 rtl/decode.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_decode.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : riscv_structures                                             |
// | Description : Shared types for the RV32I decode stage: fetch->decode and   |
// |               decode->execute bundles, opcode / ALU / writeback / memory   |
// |               size enums, immediate-format enum, opcode and funct7         |
// |               constants and the immediate builder.                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package riscv_structures;

    localparam int RV_XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [6:0] {
        OPCODE_LUI    = OPC_LUI,
        OPCODE_AUIPC  = OPC_AUIPC,
        OPCODE_JAL    = OPC_JAL,
        OPCODE_JALR   = OPC_JALR,
        OPCODE_BRANCH = OPC_BRANCH,
        OPCODE_LOAD   = OPC_LOAD,
        OPCODE_STORE  = OPC_STORE,
        OPCODE_OP_IMM = OPC_OP_IMM,
        OPCODE_OP     = OPC_OP
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS_B = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0]        instruction_value;
        logic [RV_XLEN-1:0] pc_value;
        logic               pc_r;
    } fe_to_de_s;

    typedef struct packed {
        logic               valid;
        logic               illegal;
        logic [RV_XLEN-1:0] pc_value;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [RV_XLEN-1:0] rs1_val;
        logic [RV_XLEN-1:0] rs2_val;
        logic [RV_XLEN-1:0] imm;
        alu_op_e            alu_op;
        logic               src_a_pc;
        logic               src_b_imm;
        logic               mem_read;
        logic               mem_write;
        mem_size_e          mem_size;
        logic               mem_unsigned;
        wb_sel_e            wb_sel;
        logic               reg_write;
        logic               branch;
        logic               jal;
        logic               jalr;
        logic [2:0]         funct3;      // branch condition for execute
    } de_to_ex_s;

    // Sign-extended immediate from bit 31 for each encoding format.
    function automatic logic [RV_XLEN-1:0] imm_gen(input logic [31:0] instr,
                                                    input imm_fmt_e    fmt);
        logic [RV_XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file                                                     |
// | Description : REG_COUNT x XLEN integer register file. Two combinational    |
// |               read ports with write-through bypass, one synchronous write  |
// |               port, asynchronous active-high reset. x0 reads as zero and   |
// |               ignores writes.                                              |
// | Ports       : clk, reset        clock / async reset                        |
// |               rs1_addr/rs2_addr read addresses                             |
// |               rs1_val/rs2_val   read data                                  |
// |               we, wr_addr, wr_data  write port                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module reg_file #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    input  logic            we,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_q [REG_COUNT];
    logic [XLEN-1:0] regs_d [REG_COUNT];

    always_comb begin
        regs_d = regs_q;
        if (we && (wr_addr != 5'd0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass lets decode see a value being written back in the same cycle.
    always_comb begin
        rs1_val = '0;
        if (rs1_addr != 5'd0) begin
            rs1_val = (we && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2_addr != 5'd0) begin
            rs2_val = (we && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode                                                       |
// | Description : RV32I decode stage. Decodes fe_to_de, reads rs1/rs2, builds  |
// |               the immediate, registers the result into de_to_ex, kills     |
// |               wrong-path instructions and flags load-use hazards.          |
// | Config      : DECODE_RV32M_EN - when defined, OP with funct7=0000001       |
// |               decodes to the M-extension ALU ops; otherwise it is illegal. |
// | Ports       : clk, reset (async, active-high), en, flush, fe_to_de,        |
// |               wb_we / wb_rd / wb_data (writeback), stall, de_to_ex         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module decode
    import riscv_structures::*;
#(
    parameter int XLEN      = RV_XLEN,   // must match RV_XLEN used by the bundles
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            flush,
    input  fe_to_de_s       fe_to_de,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output de_to_ex_s       de_to_ex
);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
    logic            kill;
    imm_fmt_e        imm_fmt;
    de_to_ex_s       dec;
    de_to_ex_s       de_to_ex_d;
    de_to_ex_s       de_to_ex_q;

    assign instr  = fe_to_de.instruction_value;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    reg_file #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .we       (wb_we),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    always_comb begin
        dec      = '0;
        imm_fmt  = IMM_NONE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        illegal  = 1'b0;

        case (opcode)
            OPC_LUI: begin
                imm_fmt       = IMM_U;
                dec.alu_op    = ALU_PASS_B;
                dec.src_b_imm = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_fmt       = IMM_U;
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                imm_fmt       = IMM_J;
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                rs1_used      = 1'b1;
                imm_fmt       = IMM_I;
                dec.src_b_imm = 1'b1;
                dec.jalr      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_PC4;
                illegal       = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                // ALU computes the target; execute compares rs1/rs2 by funct3.
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                imm_fmt       = IMM_B;
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.branch    = 1'b1;
                illegal       = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                rs1_used      = 1'b1;
                imm_fmt       = IMM_I;
                dec.src_b_imm = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_MEM;
                case (funct3)
                    3'b000:  dec.mem_size = MEM_B;
                    3'b001:  dec.mem_size = MEM_H;
                    3'b010:  dec.mem_size = MEM_W;
                    3'b100: begin
                        dec.mem_size     = MEM_B;
                        dec.mem_unsigned = 1'b1;
                    end
                    3'b101: begin
                        dec.mem_size     = MEM_H;
                        dec.mem_unsigned = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                imm_fmt       = IMM_S;
                dec.src_b_imm = 1'b1;
                dec.mem_write = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_size = MEM_B;
                    3'b001:  dec.mem_size = MEM_H;
                    3'b010:  dec.mem_size = MEM_W;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                rs1_used      = 1'b1;
                imm_fmt       = IMM_I;
                dec.src_b_imm = 1'b1;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b110:  dec.alu_op = ALU_OR;
                    3'b111:  dec.alu_op = ALU_AND;
                    3'b001: begin
                        // SLLI has no arithmetic variant.
                        dec.alu_op = ALU_SLL;
                        illegal    = (funct7 != F7_BASE);
                    end
                    default: begin
                        if (funct7 == F7_BASE) begin
                            dec.alu_op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec.alu_op = ALU_SRA;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                dec.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  dec.alu_op = ALU_ADD;
                        3'b001:  dec.alu_op = ALU_SLL;
                        3'b010:  dec.alu_op = ALU_SLT;
                        3'b011:  dec.alu_op = ALU_SLTU;
                        3'b100:  dec.alu_op = ALU_XOR;
                        3'b101:  dec.alu_op = ALU_SRL;
                        3'b110:  dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  dec.alu_op = ALU_SUB;
                        3'b101:  dec.alu_op = ALU_SRA;
                        default: illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
                    case (funct3)
                        3'b000:  dec.alu_op = ALU_MUL;
                        3'b001:  dec.alu_op = ALU_MULH;
                        3'b010:  dec.alu_op = ALU_MULHSU;
                        3'b011:  dec.alu_op = ALU_MULHU;
                        3'b100:  dec.alu_op = ALU_DIV;
                        3'b101:  dec.alu_op = ALU_DIVU;
                        3'b110:  dec.alu_op = ALU_REM;
                        default: dec.alu_op = ALU_REMU;
                    endcase
`else
                    illegal = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        dec.valid    = 1'b1;
        dec.pc_value = fe_to_de.pc_value;
        dec.rd       = rd;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rs1_val  = rs1_val;
        dec.rs2_val  = rs2_val;
        dec.funct3   = funct3;
        dec.imm      = imm_gen(instr, imm_fmt);

        // Illegal instructions travel on so execute can trap, but with no side effects.
        if (illegal) begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jal       = 1'b0;
            dec.jalr      = 1'b0;
        end
    end

    // Wrong-path (fetch redirect) or fetch reset value: replace with a bubble.
    assign kill = fe_to_de.pc_r || (instr == 32'h0000_0000);

    // Load in execute whose result the instruction now in decode needs.
    assign stall = de_to_ex_q.valid && de_to_ex_q.mem_read && (de_to_ex_q.rd != 5'd0)
                && (((de_to_ex_q.rd == rs1) && rs1_used)
                 || ((de_to_ex_q.rd == rs2) && rs2_used));

    always_comb begin
        de_to_ex_d = de_to_ex_q;
        if (flush) begin
            de_to_ex_d = '0;
        end else if (!en) begin
            de_to_ex_d = de_to_ex_q;
        end else if (stall || kill) begin
            de_to_ex_d = '0;
        end else begin
            de_to_ex_d = dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_to_ex_q <= '0;
        end else begin
            de_to_ex_q <= de_to_ex_d;
        end
    end

    assign de_to_ex = de_to_ex_q;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decode                                                    |
// | Description : Directed self-checking bench for the decode stage.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_decode;
    import riscv_structures::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic        flush;
    fe_to_de_s   fe_to_de;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    de_to_ex_s   de_to_ex;

    int n_tests = 0;
    int n_fail  = 0;

    decode dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .flush    (flush),
        .fe_to_de (fe_to_de),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .stall    (stall),
        .de_to_ex (de_to_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fe(input logic [31:0] ins, input logic [31:0] pc);
        fe_to_de.instruction_value = ins;
        fe_to_de.pc_value          = pc;
        fe_to_de.pc_r              = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        flush   = 1'b0;
        wb_we   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = 32'h0;
        set_fe(32'h0, 32'h0);

        tick();
        chk("rst_valid", 32'(de_to_ex.valid), 32'd0);
        chk("rst_pc", de_to_ex.pc_value, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        // Write x5, then read it back through add x6,x5,x5.
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
        tick();
        wb_we = 1'b0;
        chk("kill_zero_instr", 32'(de_to_ex.valid), 32'd0);
        set_fe(32'h0052_8333, 32'h40);
        tick();
        chk("x5_written", de_to_ex.rs1_val, 32'h0000_1234);
        chk("add_valid", 32'(de_to_ex.valid), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(de_to_ex.valid), 32'd0);
        chk("midrst_pc", de_to_ex.pc_value, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("x5_cleared", de_to_ex.rs1_val, 32'h0);

        // addi x1,x0,10 at 0x100
        set_fe(32'h00A0_0093, 32'h100);
        tick();
        chk("addi_valid", 32'(de_to_ex.valid), 32'd1);
        chk("addi_rd", 32'(de_to_ex.rd), 32'd1);
        chk("addi_imm", de_to_ex.imm, 32'd10);
        chk("addi_srcb", 32'(de_to_ex.src_b_imm), 32'd1);
        chk("addi_we", 32'(de_to_ex.reg_write), 32'd1);
        chk("addi_pc", de_to_ex.pc_value, 32'h100);
        chk("addi_alu", 32'(de_to_ex.alu_op), 32'(ALU_ADD));

        // lw x2,0(x1) followed by add x3,x2,x2 -> load-use stall
        set_fe(32'h0000_A103, 32'h104);
        tick();
        chk("lw_memrd", 32'(de_to_ex.mem_read), 32'd1);
        chk("lw_size", 32'(de_to_ex.mem_size), 32'(MEM_W));
        set_fe(32'h0021_01B3, 32'h108);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(de_to_ex.valid), 32'd0);
        chk("lu_stall_clr", 32'(stall), 32'd0);
        // Writeback of x2 in the same cycle the add is decoded.
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_we = 1'b0;
        chk("lu_add_valid", 32'(de_to_ex.valid), 32'd1);
        chk("lu_add_rd", 32'(de_to_ex.rd), 32'd3);
        chk("lu_add_pc", de_to_ex.pc_value, 32'h108);
        chk("bypass_rs1", de_to_ex.rs1_val, 32'hDEAD_BEEF);
        chk("bypass_rs2", de_to_ex.rs2_val, 32'hDEAD_BEEF);
        set_fe(32'h0021_01B3, 32'h10C);
        tick();
        chk("x2_stored", de_to_ex.rs1_val, 32'hDEAD_BEEF);

        // Load to x0 never stalls.
        set_fe(32'h0000_A003, 32'h110);
        tick();
        set_fe(32'h0021_01B3, 32'h114);
        #1;
        chk("ld_x0_memrd", 32'(de_to_ex.mem_read), 32'd1);
        chk("ld_x0_nostall", 32'(stall), 32'd0);
        tick();
        chk("ld_x0_next_pc", de_to_ex.pc_value, 32'h114);

        // Writeback to x0 is ignored, including the bypass.
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        set_fe(32'h0000_01B3, 32'h118);
        tick();
        wb_we = 1'b0;
        chk("x0_bypass", de_to_ex.rs1_val, 32'h0);
        tick();
        chk("x0_stays", de_to_ex.rs2_val, 32'h0);

        // en=0 holds; flush with en=0 still bubbles.
        set_fe(32'h00A0_0093, 32'h200);
        tick();
        en = 1'b0;
        set_fe(32'h1234_50B7, 32'h204);
        tick();
        chk("hold_pc", de_to_ex.pc_value, 32'h200);
        chk("hold_valid", 32'(de_to_ex.valid), 32'd1);
        flush = 1'b1;
        tick();
        chk("flush_bubble", 32'(de_to_ex.valid), 32'd0);
        flush = 1'b0;
        en    = 1'b1;
        tick();
        chk("lui_imm", de_to_ex.imm, 32'h1234_5000);
        chk("lui_alu", 32'(de_to_ex.alu_op), 32'(ALU_PASS_B));

        // Redirect kill.
        set_fe(32'h00A0_0093, 32'h208);
        fe_to_de.pc_r = 1'b1;
        tick();
        chk("pcr_bubble", 32'(de_to_ex.valid), 32'd0);
        chk("pcr_we", 32'(de_to_ex.reg_write), 32'd0);

        // beq x0,x0,-4
        set_fe(32'hFE00_0EE3, 32'h20C);
        tick();
        chk("beq_imm", de_to_ex.imm, 32'hFFFF_FFFC);
        chk("beq_branch", 32'(de_to_ex.branch), 32'd1);
        chk("beq_we", 32'(de_to_ex.reg_write), 32'd0);

        // sw x2,-8(x1)
        set_fe(32'hFE20_AC23, 32'h210);
        tick();
        chk("sw_imm", de_to_ex.imm, 32'hFFFF_FFF8);
        chk("sw_memwr", 32'(de_to_ex.mem_write), 32'd1);

        // Shift-immediate with bad funct7, and an unknown opcode.
        set_fe(32'h0400_5013, 32'h214);
        tick();
        chk("srli_illegal", 32'(de_to_ex.illegal), 32'd1);
        chk("srli_valid", 32'(de_to_ex.valid), 32'd1);
        chk("srli_we", 32'(de_to_ex.reg_write), 32'd0);
        set_fe(32'h0000_007F, 32'h218);
        tick();
        chk("unk_illegal", 32'(de_to_ex.illegal), 32'd1);

        // mul x0,x1,x2
        set_fe(32'h0220_8033, 32'h21C);
        tick();
`ifdef DECODE_RV32M_EN
        chk("mul_illegal", 32'(de_to_ex.illegal), 32'd0);
        chk("mul_alu", 32'(de_to_ex.alu_op), 32'(ALU_MUL));
`else
        chk("mul_illegal", 32'(de_to_ex.illegal), 32'd1);
        chk("mul_we", 32'(de_to_ex.reg_write), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
